alu_stage: RTL and testbench
============================

Name: alu_stage

Overview:
- Stage 4 of the CPU pipeline: sits between stage3 (RAM read) and stage5 (RAM save).
- Owns the 8-bit register file and flags. Executes one decoded operation per exec handshake.
- Takes operands from registers, an immediate, or the byte stage3 just read.
- For store operations, produces the address/value request that stage5 consumes.

Parameters:
REG_COUNT, 16, number of 8-bit general registers
REG_IDX_W, 4, register index width (clog2 of REG_COUNT)

Ports:
ram_clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
stage4_exec  in  1  start request; level, held by controller until stage4_exec_ready
stage4_exec_ready  out  1  operation complete; high while in DONE
stage4_oper  in  5  operation code (OPER_*)
stage4_dst  in  REG_IDX_W  destination register
stage4_src_a  in  REG_IDX_W  operand A register
stage4_src_b  in  REG_IDX_W  operand B register
stage4_imm  in  8  immediate / low save address
stage4_ram_data  in  8  byte delivered by stage3
stage5_should_exec  out  1  store request valid for stage5
stage5_save_address  out  16  save address for stage5
stage5_save_value  out  8  save data for stage5
flag_zero  out  1  Z flag
flag_carry  out  1  C flag (carry/borrow/overflow)
flag_negative  out  1  N flag (result bit 7)

Behaviour:
- Reset (async): all registers 0x00, state IDLE. All outputs 0, including flags and stage5_* fields. Any in-flight op is abandoned with no write-back.
- FSM: IDLE -> OPERAND -> EXEC -> DONE -> IDLE.
- IDLE: stage4_exec_ready=0. When stage4_exec=1 at an edge, latch oper/dst/src_a/src_b/imm/ram_data and go to OPERAND. Later input changes are ignored until the next start.
- OPERAND: read regs[src_a] and regs[src_b] into A/B. Clear stage5_should_exec.
- EXEC: compute result.
  - Single-cycle ops go to DONE the next edge.
  - OPER_MUL starts the alu_mul8 sub-module and stays in EXEC until its done pulse (8 cycles total in EXEC).
- DONE: stage4_exec_ready=1, write-back and flags committed on the entry edge. Stay while stage4_exec=1; go to IDLE on the first edge with stage4_exec=0.
- Latency, exec sampled at edge 0:
  - Single-cycle ops: ready high after edge 3.
  - MUL: ready high after edge 10.
- exec dropped before DONE: the op still completes, ready is high for exactly one cycle, then IDLE.
- Operations (A, B, imm are 8-bit unsigned):
  - OPER_ADD=1: dst=A+B. C=bit 8 of the 9-bit sum.
  - OPER_SUB=2: dst=A-B mod 256. C=1 iff A<B.
  - OPER_AND=3 / OPER_OR=4 / OPER_XOR=5: bitwise. C=0.
  - OPER_MUL=6: dst=low byte of A*B. C=1 iff high byte != 0. Shift-add, one bit per cycle.
  - OPER_LOADRAM=7: dst=ram_data. C unchanged.
  - OPER_LOADIMM=8: dst=imm. C unchanged.
  - OPER_STORE=9: no write-back, flags unchanged. stage5_save_address={8'h00,imm}, stage5_save_value=A, stage5_should_exec=1 from DONE entry until next OPERAND.
  - Any other code: no write, flags unchanged, no store request. Handshake still completes normally.
- Z=(result==0) and N=result[7] for all ops that write dst.
- dst equal to src_a or src_b: operands are read in OPERAND before the write, so the old value is used.
- Address width: only the low REG_IDX_W bits of index ports are used.

Decomposition:
- Shared package cpu_pkg holds:
  - OPER_* codes (5-bit; OPER_ADD=1 matches the existing ALU definition).
  - ALU state enum (IDLE, OPERAND, EXEC, DONE).
  - Default REG_COUNT.
- One sub-module: alu_mul8.
  - Ports: ram_clk, rst, start, a[8], b[8], done, product[16].
  - 8-iteration shift-add, done pulses one cycle.
- Register file and FSM stay in alu_stage.

Test Plan:
- Reset, then LOADIMM r1=0x7F and LOADIMM r2=0x01, then ADD r3=r1+r2 -> ready exactly 3 cycles after exec; Z=0, N=1, C=0. A following STORE r3, imm=0x40 gives stage5_should_exec=1, address=0x0040, value=0x80.
- LOADIMM r4=0x01, r5=0x02; SUB r6=r4-r5 -> STORE r6 gives value 0xFF; C=1, N=1, Z=0. Then XOR r6^r6 into r6 -> Z=1, C=0, N=0.
- LOADIMM r1=0x10, r2=0x11; MUL r7=r1*r2 -> ready 10 cycles after exec; C=1; STORE r7 gives value 0x10.
- LOADRAM r8 with stage4_ram_data=0xA5, then change ram_data to 0x00 during OPERAND -> STORE r8 gives 0xA5 (latched value); C unchanged from the prior op.
- Start MUL; assert rst for 1 cycle in EXEC cycle 4 -> ready=0, flags=0, state IDLE. STORE of dst gives 0x00. A new ADD after reset completes in 3 cycles.
- oper=0x1F with exec held 5 extra cycles -> ready held high throughout DONE, no register/flag change, stage5_should_exec=0. exec low -> ready=0 one edge later.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operation codes, ALU stage FSM states, register file size.
package cpu_pkg;

  localparam int unsigned REG_COUNT_DEF = 16;
  localparam int unsigned OPER_W        = 5;

  localparam logic [OPER_W-1:0] OPER_ADD     = 5'd1;
  localparam logic [OPER_W-1:0] OPER_SUB     = 5'd2;
  localparam logic [OPER_W-1:0] OPER_AND     = 5'd3;
  localparam logic [OPER_W-1:0] OPER_OR      = 5'd4;
  localparam logic [OPER_W-1:0] OPER_XOR     = 5'd5;
  localparam logic [OPER_W-1:0] OPER_MUL     = 5'd6;
  localparam logic [OPER_W-1:0] OPER_LOADRAM = 5'd7;
  localparam logic [OPER_W-1:0] OPER_LOADIMM = 5'd8;
  localparam logic [OPER_W-1:0] OPER_STORE   = 5'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPERAND = 2'd1,
    EXEC    = 2'd2,
    DONE    = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_mul8.sv
// 8x8 shift-add multiplier. The start edge loads the operands and already
// accumulates bit 0, so the remaining seven bits take seven more edges and
// done pulses for one cycle right after the last accumulate.
module alu_mul8 (
  input  logic        ram_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        done,
  output logic [15:0] product
);

  logic [15:0] mcand;
  logic [15:0] acc;
  logic [7:0]  mplier;
  logic [2:0]  cnt;
  logic        busy;

  // Shift-add iteration, one multiplier bit per cycle
  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (start) begin
      mcand  <= {7'b0, a, 1'b0};
      mplier <= {1'b0, b[7:1]};
      acc    <= b[0] ? {8'h00, a} : 16'h0000;
      cnt    <= 3'd1;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (busy) begin
      acc    <= acc + (mplier[0] ? mcand : 16'h0000);
      mcand  <= {mcand[14:0], 1'b0};
      mplier <= {1'b0, mplier[7:1]};
      cnt    <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_stage.sv
// Pipeline stage 4: register file, flags and ALU execution with a
// level exec / ready handshake; STORE produces a request for stage 5.
module alu_stage
  import cpu_pkg::*;
#(
  parameter int unsigned REG_COUNT = REG_COUNT_DEF,
  parameter int unsigned REG_IDX_W = $clog2(REG_COUNT)
) (
  input  logic                 ram_clk,
  input  logic                 rst,
  input  logic                 stage4_exec,
  output logic                 stage4_exec_ready,
  input  logic [4:0]           stage4_oper,
  input  logic [REG_IDX_W-1:0] stage4_dst,
  input  logic [REG_IDX_W-1:0] stage4_src_a,
  input  logic [REG_IDX_W-1:0] stage4_src_b,
  input  logic [7:0]           stage4_imm,
  input  logic [7:0]           stage4_ram_data,
  output logic                 stage5_should_exec,
  output logic [15:0]          stage5_save_address,
  output logic [7:0]           stage5_save_value,
  output logic                 flag_zero,
  output logic                 flag_carry,
  output logic                 flag_negative
);

  alu_state_e state, state_next;

  logic [4:0]           oper_q;
  logic [REG_IDX_W-1:0] dst_q;
  logic [REG_IDX_W-1:0] src_a_q;
  logic [REG_IDX_W-1:0] src_b_q;
  logic [7:0]           imm_q;
  logic [7:0]           ram_q;
  logic [7:0]           a_q;
  logic [7:0]           b_q;
  logic [7:0]           regs [REG_COUNT];

  logic [7:0]  rd_a;
  logic [7:0]  rd_b;
  logic        mul_start;
  logic        mul_done;
  logic [15:0] mul_product;
  logic [7:0]  result;
  logic        carry_next;
  logic        writes_dst;
  logic        commit;

  assign rd_a      = regs[src_a_q];
  assign rd_b      = regs[src_b_q];
  // Multiplier is loaded from the same register reads that fill A/B
  assign mul_start = (state == OPERAND) && (oper_q == OPER_MUL);
  assign commit    = (state == EXEC) && (state_next == DONE);

  alu_mul8 u_mul (
    .ram_clk (ram_clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (rd_a),
    .b       (rd_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // State register
  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (stage4_exec) state_next = OPERAND;
      OPERAND: state_next = EXEC;
      EXEC:    if ((oper_q != OPER_MUL) || mul_done) state_next = DONE;
      DONE:    if (!stage4_exec) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result and carry for the latched operation
  always_comb begin
    result     = 8'h00;
    carry_next = flag_carry;
    writes_dst = 1'b1;
    case (oper_q)
      OPER_ADD:     {carry_next, result} = 9'(a_q) + 9'(b_q);
      OPER_SUB: begin
        result     = a_q - b_q;
        carry_next = (a_q < b_q);
      end
      OPER_AND: begin
        result     = a_q & b_q;
        carry_next = 1'b0;
      end
      OPER_OR: begin
        result     = a_q | b_q;
        carry_next = 1'b0;
      end
      OPER_XOR: begin
        result     = a_q ^ b_q;
        carry_next = 1'b0;
      end
      OPER_MUL: begin
        result     = mul_product[7:0];
        carry_next = |mul_product[15:8];
      end
      OPER_LOADRAM: result = ram_q;
      OPER_LOADIMM: result = imm_q;
      default:      writes_dst = 1'b0;
    endcase
  end

  // Capture the request at start, then the operands in OPERAND
  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      oper_q  <= '0;
      dst_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      imm_q   <= '0;
      ram_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if ((state == IDLE) && stage4_exec) begin
      oper_q  <= stage4_oper;
      dst_q   <= stage4_dst;
      src_a_q <= stage4_src_a;
      src_b_q <= stage4_src_b;
      imm_q   <= stage4_imm;
      ram_q   <= stage4_ram_data;
    end else if (state == OPERAND) begin
      a_q <= rd_a;
      b_q <= rd_b;
    end
  end

  // Register file and flags, committed on DONE entry
  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_COUNT); i++) regs[i] <= 8'h00;
      flag_zero     <= 1'b0;
      flag_carry    <= 1'b0;
      flag_negative <= 1'b0;
    end else if (commit && writes_dst) begin
      regs[dst_q]   <= result;
      flag_zero     <= (result == 8'h00);
      flag_carry    <= carry_next;
      flag_negative <= result[7];
    end
  end

  // Handshake and store request toward stage 5
  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      stage4_exec_ready   <= 1'b0;
      stage5_should_exec  <= 1'b0;
      stage5_save_address <= 16'h0000;
      stage5_save_value   <= 8'h00;
    end else begin
      stage4_exec_ready <= (state_next == DONE);
      if (state_next == OPERAND) begin
        stage5_should_exec <= 1'b0;
      end else if (commit && (oper_q == OPER_STORE)) begin
        stage5_should_exec  <= 1'b1;
        stage5_save_address <= {8'h00, imm_q};
        stage5_save_value   <= a_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: vector table plus hand-written corner sequences.
module tb_alu_stage;
  import cpu_pkg::*;

  logic        ram_clk;
  logic        rst;
  logic        stage4_exec;
  logic        stage4_exec_ready;
  logic [4:0]  stage4_oper;
  logic [3:0]  stage4_dst;
  logic [3:0]  stage4_src_a;
  logic [3:0]  stage4_src_b;
  logic [7:0]  stage4_imm;
  logic [7:0]  stage4_ram_data;
  logic        stage5_should_exec;
  logic [15:0] stage5_save_address;
  logic [7:0]  stage5_save_value;
  logic        flag_zero;
  logic        flag_carry;
  logic        flag_negative;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  oper;
    logic [3:0]  dst;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [7:0]  imm;
    logic [7:0]  ram;
    int          lat;
    int          hold;
    logic        z;
    logic        c;
    logic        n;
    logic        se;
    logic [15:0] addr;
    logic [7:0]  val;
  } vec_t;

  vec_t vecs[$];

  alu_stage dut (
    .ram_clk             (ram_clk),
    .rst                 (rst),
    .stage4_exec         (stage4_exec),
    .stage4_exec_ready   (stage4_exec_ready),
    .stage4_oper         (stage4_oper),
    .stage4_dst          (stage4_dst),
    .stage4_src_a        (stage4_src_a),
    .stage4_src_b        (stage4_src_b),
    .stage4_imm          (stage4_imm),
    .stage4_ram_data     (stage4_ram_data),
    .stage5_should_exec  (stage5_should_exec),
    .stage5_save_address (stage5_save_address),
    .stage5_save_value   (stage5_save_value),
    .flag_zero           (flag_zero),
    .flag_carry          (flag_carry),
    .flag_negative       (flag_negative)
  );

  initial ram_clk = 1'b0;
  always #5 ram_clk = ~ram_clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] oper, input logic [3:0] dst, input logic [3:0] sa,
                              input logic [3:0] sb, input logic [7:0] imm, input logic [7:0] ram,
                              input int lat, input int hold, input logic z, input logic c,
                              input logic n, input logic se, input logic [15:0] addr,
                              input logic [7:0] val);
    vec_t v;
    v.oper = oper; v.dst = dst; v.src_a = sa; v.src_b = sb; v.imm = imm; v.ram = ram;
    v.lat = lat; v.hold = hold; v.z = z; v.c = c; v.n = n; v.se = se; v.addr = addr; v.val = val;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    stage4_oper     = v.oper;
    stage4_dst      = v.dst;
    stage4_src_a    = v.src_a;
    stage4_src_b    = v.src_b;
    stage4_imm      = v.imm;
    stage4_ram_data = v.ram;
    stage4_exec     = 1'b1;
  endtask

  task automatic check_flags(input string tag, input logic z, input logic c, input logic n);
    check({tag, ".z"}, 16'(flag_zero), 16'(z));
    check({tag, ".c"}, 16'(flag_carry), 16'(c));
    check({tag, ".n"}, 16'(flag_negative), 16'(n));
  endtask

  // Apply one operation; inputs other than exec are scrambled after the start edge.
  task automatic run_op(input string tag, input vec_t v);
    int lat;
    drive(v);
    lat = 0;
    do begin
      @(posedge ram_clk); #1;
      lat++;
      if (lat == 1) begin
        stage4_ram_data = 8'h00;
        stage4_imm      = ~v.imm;
        stage4_dst      = ~v.dst;
        stage4_src_a    = ~v.src_a;
      end
    end while (!stage4_exec_ready && lat < 30);
    check({tag, ".latency"}, 16'(lat), 16'(v.lat));
    for (int h = 0; h < v.hold; h++) begin
      @(posedge ram_clk); #1;
      check({tag, ".ready_hold"}, 16'(stage4_exec_ready), 16'd1);
    end
    check_flags(tag, v.z, v.c, v.n);
    check({tag, ".se"}, 16'(stage5_should_exec), 16'(v.se));
    if (v.se) begin
      check({tag, ".addr"}, stage5_save_address, v.addr);
      check({tag, ".val"}, 16'(stage5_save_value), 16'(v.val));
    end
    stage4_exec = 1'b0;
    @(posedge ram_clk); #1;
    check({tag, ".ready_drop"}, 16'(stage4_exec_ready), 16'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    stage4_exec = 1'b0;
    stage4_oper = '0; stage4_dst = '0; stage4_src_a = '0; stage4_src_b = '0;
    stage4_imm = '0; stage4_ram_data = '0;
    repeat (2) @(posedge ram_clk);
    #1;
    check("reset.ready", 16'(stage4_exec_ready), 16'd0);
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check("reset.se", 16'(stage5_should_exec), 16'd0);
    check("reset.addr", stage5_save_address, 16'h0000);
    check("reset.val", 16'(stage5_save_value), 16'h0000);
    rst = 1'b0;
    @(posedge ram_clk); #1;

    //            oper          dst sa  sb  imm    ram    lat hold z  c  n  se addr      val
    vecs.push_back(mk(OPER_LOADIMM, 1, 0, 0, 8'h7F, 8'h00, 3, 0, 0, 0, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_LOADIMM, 2, 0, 0, 8'h01, 8'h00, 3, 0, 0, 0, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_ADD,     3, 1, 2, 8'h00, 8'h00, 3, 0, 0, 0, 1, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_STORE,   0, 3, 0, 8'h40, 8'h00, 3, 0, 0, 0, 1, 1, 16'h0040, 8'h80));
    vecs.push_back(mk(OPER_LOADIMM, 4, 0, 0, 8'h01, 8'h00, 3, 0, 0, 0, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_LOADIMM, 5, 0, 0, 8'h02, 8'h00, 3, 0, 0, 0, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_SUB,     6, 4, 5, 8'h00, 8'h00, 3, 0, 0, 1, 1, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_STORE,   0, 6, 0, 8'h41, 8'h00, 3, 0, 0, 1, 1, 1, 16'h0041, 8'hFF));
    vecs.push_back(mk(OPER_XOR,     6, 6, 6, 8'h00, 8'h00, 3, 0, 1, 0, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_LOADIMM, 1, 0, 0, 8'h10, 8'h00, 3, 0, 0, 0, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_LOADIMM, 2, 0, 0, 8'h11, 8'h00, 3, 0, 0, 0, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_MUL,     7, 1, 2, 8'h00, 8'h00, 10, 0, 0, 1, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_STORE,   0, 7, 0, 8'h42, 8'h00, 3, 0, 0, 1, 0, 1, 16'h0042, 8'h10));
    vecs.push_back(mk(5'h1F,        7, 1, 2, 8'h00, 8'h00, 3, 5, 0, 1, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_LOADRAM, 8, 0, 0, 8'h00, 8'hA5, 3, 0, 0, 1, 1, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_STORE,   0, 8, 0, 8'h43, 8'h00, 3, 0, 0, 1, 1, 1, 16'h0043, 8'hA5));
    vecs.push_back(mk(OPER_ADD,     9, 3, 3, 8'h00, 8'h00, 3, 0, 1, 1, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_STORE,   0, 9, 0, 8'hFF, 8'h00, 3, 0, 1, 1, 0, 1, 16'h00FF, 8'h00));
    vecs.push_back(mk(OPER_OR,     10, 3, 5, 8'h00, 8'h00, 3, 0, 0, 0, 1, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_AND,    11, 1, 2, 8'h00, 8'h00, 3, 0, 0, 0, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_MUL,    12, 7, 0, 8'h00, 8'h00, 10, 0, 1, 0, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_LOADIMM,13, 0, 0, 8'hFF, 8'h00, 3, 0, 0, 0, 1, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_MUL,    14,13,13, 8'h00, 8'h00, 10, 0, 0, 1, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_STORE,   0,14, 0, 8'h48, 8'h00, 3, 0, 0, 1, 0, 1, 16'h0048, 8'h01));
    vecs.push_back(mk(OPER_ADD,    13,13,13, 8'h00, 8'h00, 3, 0, 0, 1, 1, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(OPER_STORE,   0,13, 0, 8'h44, 8'h00, 3, 0, 0, 1, 1, 1, 16'h0044, 8'hFE));
    vecs.push_back(mk(OPER_STORE,   0, 7, 0, 8'h45, 8'h00, 3, 0, 0, 1, 1, 1, 16'h0045, 8'h10));

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

    // exec dropped right after the start edge: op completes, ready lasts one cycle
    drive(mk(OPER_LOADIMM, 15, 0, 0, 8'h5A, 8'h00, 3, 0, 0, 0, 0, 0, 16'h0000, 8'h00));
    @(posedge ram_clk); #1;
    stage4_exec = 1'b0;
    lat = 1;
    while (!stage4_exec_ready && lat < 30) begin
      @(posedge ram_clk); #1;
      lat++;
    end
    check("early_drop.latency", 16'(lat), 16'd3);
    check_flags("early_drop", 1'b0, 1'b1, 1'b0);
    @(posedge ram_clk); #1;
    check("early_drop.ready_one_cycle", 16'(stage4_exec_ready), 16'd0);
    run_op("early_drop.store",
           mk(OPER_STORE, 0, 15, 0, 8'h46, 8'h00, 3, 0, 0, 1, 0, 1, 16'h0046, 8'h5A));

    // Reset in the fourth MUL execute cycle abandons the op and clears everything
    drive(mk(OPER_MUL, 7, 1, 2, 8'h00, 8'h00, 10, 0, 0, 0, 0, 0, 16'h0000, 8'h00));
    repeat (5) @(posedge ram_clk);
    #1;
    rst = 1'b1;
    stage4_exec = 1'b0;
    #1;
    check("midreset.ready", 16'(stage4_exec_ready), 16'd0);
    check_flags("midreset", 1'b0, 1'b0, 1'b0);
    check("midreset.se", 16'(stage5_should_exec), 16'd0);
    check("midreset.addr", stage5_save_address, 16'h0000);
    check("midreset.val", 16'(stage5_save_value), 16'h0000);
    @(posedge ram_clk); #1;
    rst = 1'b0;
    @(posedge ram_clk); #1;
    check("midreset.idle_ready", 16'(stage4_exec_ready), 16'd0);
    run_op("post_reset.store",
           mk(OPER_STORE, 0, 7, 0, 8'h47, 8'h00, 3, 0, 0, 0, 0, 1, 16'h0047, 8'h00));
    run_op("post_reset.add",
           mk(OPER_ADD, 3, 1, 2, 8'h00, 8'h00, 3, 0, 1, 0, 0, 0, 16'h0000, 8'h00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
